// File: rtl/riscv_core_div_sequencer.sv
// Multi-cycle RV64M divide sequencer (DIV/DIVU/REM/REMU and W variants).
// Restoring divider, one quotient bit per cycle. Special cases
// (divide-by-zero, signed overflow) complete right after acceptance.
module riscv_core_div_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            i_div_clk,
  input  logic            i_div_rst_n,
  input  logic            i_div_valid,
  output logic            o_div_ready,
  input  logic [2:0]      i_div_funct3,
  input  logic            i_div_word,
  input  logic [XLEN-1:0] i_div_rs1,
  input  logic [XLEN-1:0] i_div_rs2,
  input  logic            i_div_flush,
  output logic            o_div_valid,
  output logic [XLEN-1:0] o_div_result,
  input  logic            i_div_result_ready
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dsr;
  logic [CW-1:0]   cnt;
  logic            sign_q;
  logic            sign_r;
  logic            sel_rem;
  logic            word_q;

  logic            accept;
  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic            is_zero;
  logic            is_ovf;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] min_val;
  logic [XLEN-1:0] spec_sel;
  logic [XLEN-1:0] spec_res;
  logic [XLEN-1:0] dvd_init;

  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN:0]   rem_nx;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] sel_fix;
  logic [XLEN-1:0] res_fix;

  // Operand preparation, evaluated on the request inputs. The PREP step is
  // folded into the acceptance edge so that a normal op takes N+2 edges and
  // a special case takes a single edge.
  always_comb begin
    accept    = i_div_valid & o_div_ready & ~i_div_flush & i_div_funct3[2];
    signed_op = ~i_div_funct3[0];
    if (i_div_word) begin
      a_ext   = {{(XLEN-32){signed_op & i_div_rs1[31]}}, i_div_rs1[31:0]};
      b_ext   = {{(XLEN-32){signed_op & i_div_rs2[31]}}, i_div_rs2[31:0]};
      min_val = {{(XLEN-31){1'b1}}, {31{1'b0}}};
    end else begin
      a_ext   = i_div_rs1;
      b_ext   = i_div_rs2;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = signed_op & a_ext[XLEN-1];
    b_neg    = signed_op & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    is_zero  = (b_ext == '0);
    is_ovf   = signed_op & (a_ext == min_val) & (b_ext == '1);
    if (is_zero) spec_sel = i_div_funct3[1] ? a_ext : '1;
    else         spec_sel = i_div_funct3[1] ? '0 : a_ext;
    spec_res = i_div_word ? {{(XLEN-32){spec_sel[31]}}, spec_sel[31:0]} : spec_sel;
    // Word dividends sit at the top so the same MSB-first shift applies.
    dvd_init = i_div_word ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
  end

  // One restoring iteration plus the sign fix-up and result selection.
  always_comb begin
    rem_sh  = {rem[XLEN-1:0], quo[XLEN-1]};
    ge      = (rem_sh >= {1'b0, dsr});
    rem_nx  = ge ? (rem_sh - {1'b0, dsr}) : rem_sh;
    q_fix   = sign_q ? -quo : quo;
    r_fix   = sign_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    sel_fix = sel_rem ? r_fix : q_fix;
    res_fix = word_q ? {{(XLEN-32){sel_fix[31]}}, sel_fix[31:0]} : sel_fix;
  end

  // Sequencer FSM with registered handshake outputs and result.
  always_ff @(posedge i_div_clk or negedge i_div_rst_n) begin
    if (!i_div_rst_n) begin
      state        <= S_IDLE;
      o_div_ready  <= 1'b1;
      o_div_valid  <= 1'b0;
      o_div_result <= '0;
      rem          <= '0;
      quo          <= '0;
      dsr          <= '0;
      cnt          <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      sel_rem      <= 1'b0;
      word_q       <= 1'b0;
    end else if (i_div_flush) begin
      state       <= S_IDLE;
      o_div_ready <= 1'b1;
      o_div_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            o_div_ready <= 1'b0;
            sign_q      <= a_neg ^ b_neg;
            sign_r      <= a_neg;
            sel_rem     <= i_div_funct3[1];
            word_q      <= i_div_word;
            if (is_zero || is_ovf) begin
              o_div_result <= spec_res;
              o_div_valid  <= 1'b1;
              state        <= S_DONE;
            end else begin
              rem   <= '0;
              quo   <= dvd_init;
              dsr   <= b_mag;
              cnt   <= i_div_word ? CW'(32) : CW'(XLEN);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem <= rem_nx;
          quo <= {quo[XLEN-2:0], ge};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          o_div_result <= res_fix;
          o_div_valid  <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: begin
          if (i_div_result_ready) begin
            o_div_valid <= 1'b0;
            o_div_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          o_div_ready <= 1'b1;
          o_div_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
